// File: rtl/mc14500b_loader.sv
// Program loader and run controller for the MC14500B core: buffers a streamed
// program, then sequences reset / write burst / reset and watches for a halt.
module mc14500b_loader #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LEN_W   = 9,
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             word_valid,
  input  logic [11:0]      word_data,
  output logic             word_ready,
  input  logic             stop,
  input  logic [3:0]       opcode,
  output logic             core_rst,
  output logic             core_program_write,
  output logic [11:0]      core_program_cmd,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             error
);
  localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FILL, PRE_RST, BURST, POST_RST, RUN} state_t;

  state_t             state, state_next;
  logic [LEN_W-1:0]   len, wcnt, rcnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [11:0]        mem [DEPTH];

  logic len_ok, accept, last_word, last_read, timeout;
  logic error_next, done_next, halted_next;

  assign len_ok    = (load_len != '0) && (load_len <= LEN_W'(DEPTH));
  assign accept    = (state == FILL) && word_valid && !stop;
  assign last_word = (wcnt == len - LEN_W'(1));
  assign last_read = (rcnt == len);
  assign timeout   = (state == FILL) && !word_valid &&
                     (stall_cnt == STALL_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    error_next  = 1'b0;
    done_next   = 1'b0;
    halted_next = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          if (len_ok) state_next = FILL;
          else        error_next = 1'b1;
        end
      end
      FILL: begin
        if (accept && last_word) begin
          state_next = PRE_RST;
        end else if (timeout) begin
          state_next = IDLE;
          error_next = 1'b1;
        end
      end
      PRE_RST:  state_next = BURST;
      BURST:    if (last_read) state_next = POST_RST;
      POST_RST: begin
        state_next = RUN;
        done_next  = 1'b1;
      end
      RUN: begin
        if (opcode == HALT_OP) begin
          state_next  = IDLE;
          halted_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // stop overrides acceptance, timeout and halt detection
    if (stop && state != IDLE) begin
      state_next  = IDLE;
      error_next  = 1'b0;
      done_next   = 1'b0;
      halted_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len       <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == IDLE && load_start && len_ok) begin
        len       <= load_len;
        wcnt      <= '0;
        rcnt      <= '0;
        stall_cnt <= '0;
      end
      if (accept) begin
        wcnt      <= wcnt + LEN_W'(1);
        stall_cnt <= '0;
      end else if (state == FILL) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      // rcnt runs one word ahead of the word on core_program_cmd
      if (state_next == BURST) rcnt <= rcnt + LEN_W'(1);
      if (state != IDLE && state_next == IDLE) begin
        wcnt      <= '0;
        rcnt      <= '0;
        stall_cnt <= '0;
      end
    end
  end

  // NOTE: the program buffer has no reset; its contents are only read after
  // being written by the current load, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) mem[wcnt[ADDR_W-1:0]] <= word_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst           <= 1'b1;
      core_program_write <= 1'b0;
      core_program_cmd   <= '0;
      word_ready         <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      halted             <= 1'b0;
      error              <= 1'b0;
    end else begin
      core_rst           <= state_next inside {IDLE, FILL, PRE_RST, POST_RST};
      core_program_write <= state_next inside {PRE_RST, BURST, POST_RST};
      core_program_cmd   <= (state_next == BURST) ? mem[rcnt[ADDR_W-1:0]] : 12'h000;
      word_ready         <= (state_next == FILL);
      busy               <= (state_next != IDLE);
      done               <= done_next;
      halted             <= halted_next;
      error              <= error_next;
    end
  end

endmodule

// File: tb/tb_mc14500b_loader.sv
// Directed testbench for mc14500b_loader: length-check vector table plus
// hand-written load, burst, halt, stop, timeout and reset sequences.
module tb_mc14500b_loader;
  localparam int DEPTH   = 256;
  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [8:0]  load_len;
  logic        word_valid;
  logic [11:0] word_data;
  logic        word_ready;
  logic        stop;
  logic [3:0]  opcode;
  logic        core_rst;
  logic        core_program_write;
  logic [11:0] core_program_cmd;
  logic        busy, done, halted, error;

  mc14500b_loader #(.DEPTH(DEPTH), .LEN_W(9), .TIMEOUT(TIMEOUT), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .stop(stop), .opcode(opcode), .core_rst(core_rst),
    .core_program_write(core_program_write), .core_program_cmd(core_program_cmd),
    .busy(busy), .done(done), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [8:0] len;
    logic       exp_error;
    logic       exp_busy;
  } vec_t;

  vec_t        vecs [7];
  logic [11:0] prog [DEPTH];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads prog[0..len-1], optionally stalling before word stall_at, and checks
  // the resulting reset / burst / reset sequence. stop_at >= 0 aborts the burst.
  task automatic load_program(input int len, input int stall_at, input int stall_len,
                              input int stop_at);
    int   acc = 0;
    int   stalled = 0;
    int   budget = 0;
    logic rdy, v;
    load_start = 1'b1;
    load_len   = 9'(len);
    step();
    load_start = 1'b0;
    check("fill busy", busy, 1);
    check("fill word_ready", word_ready, 1);
    check("fill core_rst", core_rst, 1);
    while (acc < len && budget < len + stall_len + 20) begin
      v = !(acc == stall_at && stalled < stall_len);
      if (!v) stalled++;
      word_valid = v;
      word_data  = v ? prog[acc] : 12'h000;
      rdy = word_ready;
      step();
      budget++;
      if (v && rdy) acc++;
    end
    word_valid = 1'b0;
    check("accept count", acc, len);
    check("pre_rst core_rst", core_rst, 1);
    check("pre_rst pw", core_program_write, 1);
    check("pre_rst cmd", core_program_cmd, 0);
    check("pre_rst word_ready", word_ready, 0);
    for (int k = 0; k < len; k++) begin
      step();
      check($sformatf("burst%0d core_rst", k), core_rst, 0);
      check($sformatf("burst%0d pw", k), core_program_write, 1);
      check($sformatf("burst%0d cmd", k), core_program_cmd, prog[k]);
      if (k == stop_at) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("burst stop busy", busy, 0);
        check("burst stop pw", core_program_write, 0);
        check("burst stop core_rst", core_rst, 1);
        return;
      end
    end
    step();
    check("post_rst core_rst", core_rst, 1);
    check("post_rst pw", core_program_write, 1);
    check("post_rst cmd", core_program_cmd, 0);
    check("post_rst done", done, 0);
    step();
    check("run done", done, 1);
    check("run core_rst", core_rst, 0);
    check("run pw", core_program_write, 0);
    check("run cmd", core_program_cmd, 0);
    check("run busy", busy, 1);
    step();
    check("done single pulse", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] base [11];
    base = '{12'h6FF, 12'hBFF, 12'hAFF, 12'h800, 12'h801, 12'h200,
             12'h401, 12'h800, 12'h801, 12'h802, 12'hC00};
    for (int i = 0; i < 11; i++) prog[i] = base[i];

    vecs[0] = '{1'b1, 9'd0,   1'b1, 1'b0};
    vecs[1] = '{1'b1, 9'd257, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 9'd511, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 9'd1,   1'b0, 1'b1};
    vecs[4] = '{1'b1, 9'd256, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 9'd0,   1'b0, 1'b0};
    vecs[6] = '{1'b0, 9'd300, 1'b0, 1'b0};

    rst = 1'b1; load_start = 1'b0; load_len = '0; word_valid = 1'b0;
    word_data = '0; stop = 1'b0; opcode = 4'h0;
    step();
    check("reset core_rst", core_rst, 1);
    check("reset pw", core_program_write, 0);
    check("reset cmd", core_program_cmd, 0);
    check("reset busy", busy, 0);
    check("reset word_ready", word_ready, 0);
    check("reset pulses", {done, halted, error}, 0);
    @(negedge clk) rst = 1'b0;
    step();

    // Length checks and IDLE behaviour
    for (int i = 0; i < 7; i++) begin
      load_start = vecs[i].start;
      load_len   = vecs[i].len;
      step();
      load_start = 1'b0;
      check($sformatf("vec%0d error", i), error, vecs[i].exp_error);
      check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      if (vecs[i].exp_busy) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
      end else begin
        step();
      end
      check($sformatf("vec%0d error cleared", i), error, 0);
      check($sformatf("vec%0d back idle", i), busy, 0);
    end

    // Back-to-back load, then ignored load_start and halt in RUN
    load_program(11, -1, 0, -1);
    load_start = 1'b1;
    load_len   = 9'd0;
    step();
    load_start = 1'b0;
    check("run ignores load_start error", error, 0);
    check("run ignores load_start busy", busy, 1);
    opcode = 4'hF;
    step();
    opcode = 4'h0;
    check("halt pulse", halted, 1);
    check("halt core_rst", core_rst, 1);
    check("halt busy", busy, 0);
    step();
    check("halt single pulse", halted, 0);

    // Stalled stream, then stop beats halt in the same RUN cycle
    load_program(11, 4, 5, -1);
    stop   = 1'b1;
    opcode = 4'hF;
    step();
    stop   = 1'b0;
    opcode = 4'h0;
    check("stop over halt halted", halted, 0);
    check("stop over halt busy", busy, 0);
    check("stop over halt core_rst", core_rst, 1);
    step();
    check("stop over halt later", halted, 0);

    // Stop during BURST
    load_program(11, -1, 0, 5);
    step();
    check("after burst stop error", error, 0);

    // Fill timeout: two of four words, then silence
    load_start = 1'b1;
    load_len   = 9'd4;
    step();
    load_start = 1'b0;
    word_valid = 1'b1;
    word_data  = prog[0];
    step();
    word_data  = prog[1];
    step();
    word_valid = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("pre-timeout busy", busy, 1);
    check("pre-timeout error", error, 0);
    step();
    check("timeout error", error, 1);
    check("timeout busy", busy, 0);
    check("timeout core_rst", core_rst, 1);
    check("timeout word_ready", word_ready, 0);
    step();
    check("timeout single pulse", error, 0);

    // Reset asserted mid-FILL
    load_start = 1'b1;
    load_len   = 9'd11;
    step();
    load_start = 1'b0;
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word_data = prog[i];
      step();
    end
    word_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async rst core_rst", core_rst, 1);
    check("async rst pw", core_program_write, 0);
    check("async rst busy", busy, 0);
    check("async rst pulses", {done, halted, error}, 0);
    step();
    check("held rst busy", busy, 0);
    check("held rst core_rst", core_rst, 1);
    @(negedge clk) rst = 1'b0;
    step();

    // Full-depth load
    for (int i = 0; i < DEPTH; i++) prog[i] = 12'(i * 37 + 5);
    load_program(DEPTH, -1, 0, -1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("final idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mc14500b_loader.md
Name: mc14500b_loader

Overview:
- Program loader and run controller for the MC14500B core.
- Accepts a program as a valid/ready stream of 12-bit commands at any pace and buffers it in local RAM.
- Once the whole program is buffered, drives the core's rst / program_write / program_cmd pins: a reset, an uninterrupted write burst, then a second reset. The core then runs, and the loader watches its opcode for a halt instruction.

Parameters:
- DEPTH, 256: program buffer depth in words (the core's address space).
- LEN_W, 9: width of load_len; must hold DEPTH.
- TIMEOUT, 1023: maximum consecutive stall cycles tolerated while filling.
- HALT_OP, 4'hF: opcode value (NOPF) treated as program halt.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle request to load a new program; sampled only in IDLE.
- load_len  in  LEN_W  number of words to load; sampled with load_start.
- word_valid  in  1  stream word available.
- word_data  in  12  stream word: {opcode[3:0], address[7:0]}.
- word_ready  out  1  loader accepts a word this cycle.
- stop  in  1  abort the load or run and return to IDLE.
- opcode  in  4  current core instruction (instructions::instruction_t).
- core_rst  out  1  drives the core's rst.
- core_program_write  out  1  drives the core's program_write.
- core_program_cmd  out  12  drives the core's program_cmd.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on entering RUN.
- halted  out  1  one-cycle pulse when HALT_OP is seen in RUN.
- error  out  1  one-cycle pulse on bad length or fill timeout.

Behaviour:
- Reset (async) values:
  - state=IDLE, core_rst=1, core_program_write=0, core_program_cmd=0.
  - word_ready=0, busy=0, done=0, halted=0, error=0.
  - Word count, read count and stall counter all cleared.
  - Buffer contents are not reset.
- Outputs are registered. Values listed per state are those present while in that state.
- IDLE: core_rst=1, pw=0.
  - On load_start with 1<=load_len<=DEPTH: latch len, clear counters, go to FILL.
  - On load_start with load_len=0 or >DEPTH: pulse error, stay in IDLE.
- FILL: word_ready=1, core_rst=1, pw=0.
  - Each cycle with word_valid&word_ready: write buf[wcnt]=word_data, increment wcnt, clear the stall counter.
  - When the word just accepted is word len-1, go to PRE_RST; word_ready drops the next cycle.
  - The stall counter increments on cycles with no valid word. When it reaches TIMEOUT: pulse error, go to IDLE.
- PRE_RST: one cycle, core_rst=1, pw=1, cmd=0. Next state BURST.
- BURST: len consecutive cycles, core_rst=0, pw=1.
  - In the k-th BURST cycle (k=0..len-1), core_program_cmd=buf[k].
  - No gaps: the RAM read is prefetched one cycle ahead.
  - After the last word, go to POST_RST.
- POST_RST: one cycle, core_rst=1, pw=1, cmd=0. Next state RUN; done pulses on the first RUN cycle.
- RUN: core_rst=0, pw=0, cmd=0.
  - If opcode==HALT_OP: pulse halted and go to IDLE, so core_rst=1 from the next cycle.
- stop in any non-IDLE state:
  - Next state is IDLE with no error or halted pulse.
  - A partial fill is discarded and wcnt is cleared.
  - stop has priority over word acceptance and over halt detection in the same cycle.
- load_start outside IDLE is ignored.
- len=DEPTH: the last address is DEPTH-1 and the counters must not wrap before completion.
- Reset asserted mid-FILL or mid-BURST: immediate IDLE, core held in reset. A partial burst does not have to be re-sent.
- A halt on the first RUN cycle is legal: done and halted pulse in consecutive cycles.

Test Plan:
1. Reset: assert rst mid-sequence -> core_rst=1, pw=0, busy=0 and every pulse output 0 while rst is high.
2. Back-to-back load:
   - Stimulus: load_len=11, words 6FF,BFF,AFF,800,801,200,401,800,801,802,C00 with word_valid held high.
   - Response: 11 acceptances; PRE_RST 1 cycle (rst=1, pw=1).
   - Response: 11 contiguous BURST cycles emitting exactly that sequence with core_rst=0.
   - Response: POST_RST 1 cycle; done pulses once; RUN has pw=0.
3. Stalled stream:
   - Stimulus: same program with word_valid low for 5 cycles between words 3 and 4.
   - Response: burst output identical to scenario 2, with no gaps.
4. Errors:
   - load_len=0 -> error pulse, stays IDLE.
   - load_len=257 -> error pulse, stays IDLE.
   - 2 words sent of len 4, then TIMEOUT idle cycles -> error pulse, back to IDLE, core_rst=1.
5. Halt: in RUN, drive opcode=4'hF -> one halted pulse; core_rst=1 next cycle; busy=0.
6. Stop/priority:
   - stop during BURST -> IDLE next cycle, pw=0.
   - stop with opcode=4'hF in the same RUN cycle -> no halted pulse.
   - load_len=256 full load -> 256 burst cycles, last cmd=buf[255].
